// File: rtl/dec_display_2to7.sv
// Registered 2-bit to seven-segment decoder for digits 0-3, with blanking and
// lamp-test overrides. Outputs come straight from the segment register.
module dec_display_2to7 #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s0,
  input  logic s1,
  input  logic blank,
  input  logic lamp_test,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);

  // Register holds the physical pattern so the pins carry no logic after the flops.
  localparam logic [6:0] SegUnlit = {7{SEG_ACTIVE_LOW}};

  logic [6:0] logic_seg;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  always_comb begin
    logic_seg = 7'b0000000;
    if (lamp_test) begin
      logic_seg = 7'b1111111;
    end else if (blank) begin
      logic_seg = 7'b0000000;
    end else begin
      unique case ({s1, s0})
        2'b00: logic_seg = 7'b1111110;
        2'b01: logic_seg = 7'b0110000;
        2'b10: logic_seg = 7'b1101101;
        2'b11: logic_seg = 7'b1111001;
      endcase
    end
  end

  always_comb begin
    seg_d = logic_seg ^ SegUnlit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SegUnlit;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_dec_display_2to7.sv
// Directed bench for dec_display_2to7: one instance of each polarity shares the
// same inputs, so every check covers both the logical and the inverted pattern.
module tb_dec_display_2to7;

  logic clk;
  logic rst_n;
  logic s0;
  logic s1;
  logic blank;
  logic lamp_test;
  logic a0, b0, c0, d0, e0, f0, g0;
  logic a1, b1, c1, d1, e1, f1, g1;

  int testsRun = 0;
  int testsFailed = 0;

  dec_display_2to7 #(.SEG_ACTIVE_LOW(1'b0)) dutHigh (
    .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1), .blank(blank),
    .lamp_test(lamp_test),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0)
  );

  dec_display_2to7 #(.SEG_ACTIVE_LOW(1'b1)) dutLow (
    .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1), .blank(blank),
    .lamp_test(lamp_test),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] code, input logic blk, input logic lt);
    {s1, s0}  = code;
    blank     = blk;
    lamp_test = lt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected value is the logical pattern; the active-low copy must be its inverse.
  task automatic checkOutput(input string tag, input logic [6:0] expLogical);
    logic [6:0] obsHigh;
    logic [6:0] obsLow;
    obsHigh = {a0, b0, c0, d0, e0, f0, g0};
    obsLow  = {a1, b1, c1, d1, e1, f1, g1};
    testsRun++;
    assert (obsHigh === expLogical) else begin
      testsFailed++;
      $error("[TB] FAIL %s (active-high): observed %b expected %b", tag, obsHigh, expLogical);
    end
    testsRun++;
    assert (obsLow === ~expLogical) else begin
      testsFailed++;
      $error("[TB] FAIL %s (active-low): observed %b expected %b", tag, obsLow, ~expLogical);
    end
  endtask

  initial begin
    logic [1:0] codes [4];
    logic [6:0] pats  [4];
    codes = '{2'b00, 2'b01, 2'b10, 2'b11};
    pats  = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001};

    rst_n = 1'b1;
    applyStimulus(2'b11, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("preReset", 7'b1111001);

    // Reset asserted mid-cycle must clear outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("resetAsync", 7'b0000000);
    tick();
    checkOutput("resetHeld", 7'b0000000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("resetRelease", 7'b1111001);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(codes[i], 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("sweepEdge%0d", i), pats[i]);
      repeat (9) tick();
      checkOutput($sformatf("sweepHold%0d", i), pats[i]);
    end

    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("latencyStart", 7'b1111110);
    applyStimulus(2'b10, 1'b0, 1'b0);
    #2;
    checkOutput("latencyBeforeEdge", 7'b1111110);
    tick();
    checkOutput("latencyAfterEdge", 7'b1101101);

    applyStimulus(2'b01, 1'b1, 1'b0);
    tick();
    checkOutput("blank", 7'b0000000);
    applyStimulus(2'b01, 1'b1, 1'b1);
    tick();
    checkOutput("lampOverBlank", 7'b1111111);
    applyStimulus(2'b01, 1'b0, 1'b0);
    tick();
    checkOutput("overridesDropped", 7'b0110000);

    applyStimulus(2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("simulPrep", 7'b0000000);
    applyStimulus(2'b11, 1'b0, 1'b1);
    tick();
    checkOutput("simulLamp", 7'b1111111);
    applyStimulus(2'b10, 1'b0, 1'b0);
    tick();
    checkOutput("simulDecode", 7'b1101101);

    // Reset while running with a lit display.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("resetRunning", 7'b0000000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("resetRelease2", 7'b1111110);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] code;
      code = (i % 2 == 0) ? 2'b11 : 2'b00;
      applyStimulus(code, 1'b0, 1'b0);
      #2;
      checkOutput($sformatf("toggleLag%0d", i), (i % 2 == 0) ? 7'b1111110 : 7'b1111001);
      tick();
      checkOutput($sformatf("toggleNew%0d", i), (i % 2 == 0) ? 7'b1111001 : 7'b1111110);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dec_display_2to7.md
# dec_display_2to7

Registered 2-bit-to-seven-segment decoder. Converts the binary code on `s1:s0` into the segment pattern for the decimal digits 0–3 and drives the seven segment lines `a`–`g` of one display digit. It sits between the control logic that produces the 2-bit value and the display pins. Blanking and lamp-test overrides are included for board bring-up.

## Interface
- `SEG_ACTIVE_LOW`, default 0: segment polarity. 0 drives 1 = lit (common cathode). 1 inverts all seven outputs (common anode).
- `clk`  input  1  single system clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low; deassertion is synchronous to `clk`.
- `s0`  input  1  code bit 0 (LSB).
- `s1`  input  1  code bit 1 (MSB).
- `blank`  input  1  1 = all segments unlit.
- `lamp_test`  input  1  1 = all segments lit; overrides `blank`.
- `a`..`g`  output  1 each  segment drives, standard labelling: a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle.

## Operation
- Code `{s1,s0}` selects a digit. Logical segment patterns, with 1 = lit, in the order a b c d e f g:
  - 00 → digit 0: 1111110
  - 01 → digit 1: 0110000
  - 10 → digit 2: 1101101
  - 11 → digit 3: 1111001
- Override priority, highest first:
  - `lamp_test` = 1 → 1111111
  - otherwise `blank` = 1 → 0000000
  - otherwise the decoded pattern above.
- Physical output = logical pattern when `SEG_ACTIVE_LOW` = 0. When `SEG_ACTIVE_LOW` = 1, each bit is inverted.
- All four input codes are valid. There is no illegal or default state.
- Outputs come straight from a 7-bit register. No combinational path from the inputs to `a`..`g`.
- No internal state beyond the output register. No FSM.

## Timing
- Latency is 1 clock: inputs sampled at rising edge N appear on `a`..`g` immediately after edge N. An input change is therefore visible on the outputs after the next rising edge.
- Inputs must be stable around the rising edge. Asynchronous sources are synchronised upstream; no synchronisers are inside this block.
- Reset (`rst_n` = 0):
  - Immediately, without waiting for a clock, the register clears to logical 0000000, i.e. all segments unlit.
  - Physical outputs during reset are all 0 when `SEG_ACTIVE_LOW` = 0, and all 1 when `SEG_ACTIVE_LOW` = 1.
- Reset while running: outputs go unlit asynchronously and stay unlit while `rst_n` is low.
- Release: the first rising edge with `rst_n` = 1 loads the pattern for the current inputs.
- Simultaneous changes: if `lamp_test`, `blank` and the code all change in the same cycle, the next edge applies the priority above to the new values. There is no glitch or intermediate pattern.
- Throughput is one new pattern per clock. Back-to-back code changes every cycle are each shown for exactly one cycle.

## Test plan
- Reset check, `SEG_ACTIVE_LOW` = 0:
  - Assert `rst_n` = 0 mid-cycle with `{s1,s0}` = 11 → `a`..`g` = 0000000 immediately, before any clock edge.
  - Release reset, clock once → outputs = 1111001.
- Full decode sweep:
  - Apply `{s1,s0}` = 00, 01, 10, 11, one code per 100 ns hold, with `blank` = `lamp_test` = 0.
  - After the edge following each change, outputs are 1111110, 0110000, 1101101, 1111001.
- Latency check:
  - Change code 00→10 just after a rising edge → outputs remain 1111110 until the next edge, then become 1101101.
- Overrides:
  - `blank` = 1 with code 01 → 0000000.
  - Then `lamp_test` = 1 with `blank` still 1 → 1111111.
  - Drop both → 0110000 after one edge.
- Polarity, `SEG_ACTIVE_LOW` = 1:
  - Code 10 → outputs 0010010.
  - Assert reset → 1111111.
  - `lamp_test` = 1 → 0000000.
- Every-cycle toggling: alternate codes 00 and 11 on each clock → outputs alternate 1111110 and 1111001 with a one-cycle lag, with no missed or repeated patterns.
